redirect_table_ctrl: RTL
========================

# redirect_table_ctrl

Parametrised, handshake-driven controller for the initiator-port redirection table used by the AXI crossbar address-decode path. It holds a per-initiator remap entry (`map_o[i]` = physical target port for logical port i) and accepts redirect/restore commands over a valid/ready request channel. A redirect commits only once the destination port reports idle. If the port stays busy, the command waits up to a programmable timeout, then completes with an error response. It sits between the security/redirection manager and the crossbar match logic, which consumes `map_o` combinationally.

## Interface
- `N_INIT_PORT`, 8, number of table entries / initiator ports
- `LOG_N_INIT`, `$clog2(N_INIT_PORT)`, entry and index width
- `TIMEOUT_W`, 8, width of timeout counter

- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid_i`  in  1  command valid
- `req_ready_o`  out  1  command accepted when high with valid
- `req_op_i`  in  2  00 redirect, 01 restore entry, 10 restore all, 11 lock (see Configuration)
- `req_src_i`  in  LOG_N_INIT  entry index
- `req_tgt_i`  in  LOG_N_INIT  new target (redirect only)
- `timeout_i`  in  TIMEOUT_W  wait budget in cycles, sampled at accept
- `target_idle_i`  in  N_INIT_PORT  per-target idle indication
- `resp_valid_o`  out  1  command complete
- `resp_ready_i`  in  1  response consumed
- `resp_err_o`  out  1  valid with resp_valid_o: timeout / illegal / locked
- `busy_o`  out  1  FSM not in IDLE
- `map_o`  out  N_INIT_PORT×LOG_N_INIT  current table, registered

## Operation
- **Reset:**
  - `map_o[i]=i` (identity)
  - FSM=IDLE, `req_ready_o=1`, `resp_valid_o=0`, `resp_err_o=0`, `busy_o=0`
  - counter=0, all lock bits clear
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE:**
  - `req_ready_o=1`.
  - On accept, latch op/src/tgt and load counter=`timeout_i`.
  - Index ≥ N_INIT_PORT (non-power-of-two configs) → RESP, err=1, table unchanged.
  - Restore entry → `map[src]=src`, RESP.
  - Restore all → identity table, RESP.
  - Redirect with `target_idle_i[tgt]=1` → `map[src]=tgt`, RESP.
  - Redirect with target busy → WAIT.
- **WAIT:**
  - `req_ready_o=0`.
  - Each cycle, idle sampled high → commit, RESP err=0.
  - Else if counter==0 → RESP err=1, no commit.
  - Else decrement counter.
  - Idle and counter==0 in the same cycle → commit wins, err=0.
- **RESP:**
  - `resp_valid_o=1` and err held stable until `resp_ready_i`.
  - Then IDLE.
- **Restore ops never wait.** They ignore `target_idle_i`.
- **src==tgt redirect** is legal. It restores that entry, subject to the idle check.
- **Multiple entries** may map to the same target; no uniqueness check.
- **Reset mid-WAIT or mid-RESP** discards the pending command; table returns to identity.

## Timing
- Immediate commit: accepted in cycle N → `map_o` updated and `resp_valid_o=1` in N+1.
- Waited commit: idle seen in WAIT cycle M → `map_o` and `resp_valid_o` in M+1.
- Timeout: with `timeout_i=T`, WAIT occupies T+1 cycles. The error response is asserted at accept+T+2 if idle is never seen.
- `timeout_i=0`: exactly one WAIT sample, then error.
- Back-to-back: next accept no earlier than the cycle after response handshake. Maximum throughput is 1 command / 2 cycles.
- `map_o` changes only on a commit edge; never glitches between commits.

## Configuration
- **`REDIRECT_LOCK_EN` defined:**
  - Adds per-entry lock bits. Op 11 sets `lock[src]` with err=0.
  - Redirect or restore-entry to a locked src → RESP err=1, table unchanged.
  - Restore-all skips locked entries.
  - Locks clear only on reset.
- **Undefined:** op 11 is illegal → RESP err=1, no state change; no lock storage.

## Structure
- The shared package `redirect_pkg` holds:
  - `redir_op_e` (REDIR, RESTORE, RESTORE_ALL, LOCK)
  - `redir_state_e` (IDLE, WAIT, RESP)
  - the default widths
- Single sub-module `redirect_timeout_cnt`: load/decrement/zero flag, TIMEOUT_W wide.
- Table and FSM live in the top.

## Test plan
- Reset → `map_o` = {7,6,…,0} identity; `req_ready_o=1`, `resp_valid_o=0`.
- Redirect src=1 tgt=5, `target_idle_i[5]=1` → next cycle `map_o[1]=5`, `resp_valid_o=1` with err=0; hold `resp_ready_i=0` 3 cycles → response stays stable.
- Redirect src=2 tgt=3, timeout=4, idle[3] rises on 3rd WAIT cycle → `map_o[2]=3` one cycle later, err=0.
- Same command with idle[3] held low → err=1 at accept+6, `map_o[2]` still 2.
- After several redirects, restore-all → identity table in one cycle, err=0.
- With `REDIRECT_LOCK_EN`: lock 4, then redirect 4→0 → err=1, `map_o[4]=4`. Without the macro, op 11 → err=1.

Source files
------------

// File: rtl/redirect_pkg.sv
// redirect_pkg: shared command/state encodings and default widths for the redirect table.
package redirect_pkg;
    localparam int N_INIT_PORT_DEF = 8;
    localparam int TIMEOUT_W_DEF   = 8;

    typedef enum logic [1:0] {
        REDIR       = 2'b00,
        RESTORE     = 2'b01,
        RESTORE_ALL = 2'b10,
        LOCK        = 2'b11
    } redir_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } redir_state_e;
endpackage

// File: rtl/redirect_timeout_cnt.sv
// redirect_timeout_cnt: loadable down-counter bounding how long a redirect waits for its target.
// Ports: clk, rst_n (async, active-low), load/load_val (preset), dec (count down), zero (count is 0).
module redirect_timeout_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign zero = cnt == '0;
endmodule

// File: rtl/redirect_table_ctrl.sv
// redirect_table_ctrl: initiator-port remap table driven by redirect/restore commands.
// Ports: clk, rst_n (async, active-low); request channel req_valid_i/req_ready_o with
//   req_op_i, req_src_i, req_tgt_i, timeout_i; target_idle_i per-target idle flags;
//   response channel resp_valid_o/resp_ready_i with resp_err_o; busy_o (not IDLE);
//   map_o flat table, entry i at map_o[i*LOG_N_INIT +: LOG_N_INIT].
// Optional: define REDIRECT_LOCK_EN for per-entry lock bits (op LOCK); otherwise LOCK is illegal.
module redirect_table_ctrl
    import redirect_pkg::*;
#(
    parameter int N_INIT_PORT = N_INIT_PORT_DEF,
    parameter int LOG_N_INIT  = $clog2(N_INIT_PORT),
    parameter int TIMEOUT_W   = TIMEOUT_W_DEF
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic [1:0]                        req_op_i,
    input  logic [LOG_N_INIT-1:0]             req_src_i,
    input  logic [LOG_N_INIT-1:0]             req_tgt_i,
    input  logic [TIMEOUT_W-1:0]              timeout_i,
    input  logic [N_INIT_PORT-1:0]            target_idle_i,
    output logic                              resp_valid_o,
    input  logic                              resp_ready_i,
    output logic                              resp_err_o,
    output logic                              busy_o,
    output logic [N_INIT_PORT*LOG_N_INIT-1:0] map_o
);
    redir_state_e          state_q, state_d;
    redir_op_e             op;
    logic [LOG_N_INIT-1:0] map_q [N_INIT_PORT];
    logic [LOG_N_INIT-1:0] src_q, tgt_q, wr_idx, wr_val;
    logic [N_INIT_PORT-1:0] lock_mask;
    logic err_q, err_d, wr_one, wr_all, cnt_load, cnt_dec, cnt_zero, illegal;

    assign op = redir_op_e'(req_op_i);
    // Only reachable in non-power-of-two configurations; restore-all carries no index.
    assign illegal = (op != RESTORE_ALL && int'(req_src_i) >= N_INIT_PORT) ||
                     (op == REDIR && int'(req_tgt_i) >= N_INIT_PORT);

`ifdef REDIRECT_LOCK_EN
    logic                   lock_set;
    logic [N_INIT_PORT-1:0] lock_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lock_q <= '0;
        else if (lock_set)
            lock_q[req_src_i] <= 1'b1;
    end

    assign lock_mask = lock_q;
`else
    assign lock_mask = '0;
`endif

    redirect_timeout_cnt #(.W(TIMEOUT_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (timeout_i),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        wr_one   = 1'b0;
        wr_all   = 1'b0;
        wr_idx   = src_q;
        wr_val   = tgt_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
`ifdef REDIRECT_LOCK_EN
        lock_set = 1'b0;
`endif
        case (state_q)
            IDLE: if (req_valid_i) begin
                cnt_load = 1'b1;
                state_d  = RESP;
                err_d    = 1'b0;
                wr_idx   = req_src_i;
                wr_val   = req_src_i;
                if (illegal)
                    err_d = 1'b1;
                else
                    case (op)
                        REDIR: begin
                            if (lock_mask[req_src_i])
                                err_d = 1'b1;
                            else if (target_idle_i[req_tgt_i]) begin
                                wr_one = 1'b1;
                                wr_val = req_tgt_i;
                            end else
                                state_d = WAIT;
                        end
                        RESTORE: begin
                            if (lock_mask[req_src_i])
                                err_d = 1'b1;
                            else
                                wr_one = 1'b1;
                        end
                        RESTORE_ALL: wr_all = 1'b1;
                        LOCK: begin
`ifdef REDIRECT_LOCK_EN
                            lock_set = 1'b1;
`else
                            err_d = 1'b1;
`endif
                        end
                    endcase
            end
            // Idle beats an expiring counter in the same cycle.
            WAIT: begin
                if (target_idle_i[tgt_q]) begin
                    wr_one  = 1'b1;
                    state_d = RESP;
                    err_d   = 1'b0;
                end else if (cnt_zero) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else
                    cnt_dec = 1'b1;
            end
            RESP: state_d = resp_ready_i ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            src_q   <= '0;
            tgt_q   <= '0;
            for (int i = 0; i < N_INIT_PORT; i++)
                map_q[i] <= LOG_N_INIT'(i);
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (state_q == IDLE && req_valid_i) begin
                src_q <= req_src_i;
                tgt_q <= req_tgt_i;
            end
            if (wr_all) begin
                for (int i = 0; i < N_INIT_PORT; i++)
                    if (!lock_mask[i])
                        map_q[i] <= LOG_N_INIT'(i);
            end else if (wr_one)
                map_q[wr_idx] <= wr_val;
        end
    end

    assign req_ready_o  = state_q == IDLE;
    assign resp_valid_o = state_q == RESP;
    assign busy_o       = state_q != IDLE;
    assign resp_err_o   = err_q && state_q == RESP;

    for (genvar g = 0; g < N_INIT_PORT; g++) begin : g_map
        assign map_o[g*LOG_N_INIT +: LOG_N_INIT] = map_q[g];
    end
endmodule
